// File: rtl/rd_track_pipe.sv
// Destination-register tracker for the EX/MEM/WB stages: drives the regfile
// write port and resolves operand forwarding and load-use hazards for decode.
module rd_track_pipe #(
    parameter int             AW       = 5,
    parameter logic [AW-1:0]  ZERO_REG = {AW{1'b0}}
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [AW-1:0] IN_RD,
    input  logic          IN_WE,
    input  logic          IN_LOAD,
    input  logic          STALL,
    input  logic          FLUSH,
    input  logic [AW-1:0] SRC_A,
    input  logic [AW-1:0] SRC_B,
    output logic [AW-1:0] OUT_WB_RD,
    output logic          OUT_WB_WE,
    output logic [1:0]    FWD_A_SEL,
    output logic [1:0]    FWD_B_SEL,
    output logic          HAZ_LU,
    output logic          BUSY
);

    logic [AW-1:0] r_s0_rd, r_s1_rd, r_s2_rd;
    logic          r_s0_we, r_s1_we, r_s2_we;
    logic          r_s0_ld, r_s1_ld;

    logic          w_we_in;
    logic          w_ld_in;

    // Writes to the hardwired-zero register are dropped at capture.
    assign w_we_in = IN_WE & (IN_RD != ZERO_REG);
    assign w_ld_in = IN_LOAD & w_we_in;

    // Youngest writing stage that matches the source wins; zero never matches.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic [AW-1:0] rd0, input logic we0,
        input logic [AW-1:0] rd1, input logic we1,
        input logic [AW-1:0] rd2, input logic we2
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src == ZERO_REG) begin
            sel = 2'd0;
        end else if (we0 && (rd0 == src)) begin
            sel = 2'd1;
        end else if (we1 && (rd1 == src)) begin
            sel = 2'd2;
        end else if (we2 && (rd2 == src)) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Stage advance: FLUSH bubbles EX even while stalled; STALL freezes MEM/WB.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s0_rd <= {AW{1'b0}};
            r_s0_we <= 1'b0;
            r_s0_ld <= 1'b0;
            r_s1_rd <= {AW{1'b0}};
            r_s1_we <= 1'b0;
            r_s1_ld <= 1'b0;
            r_s2_rd <= {AW{1'b0}};
            r_s2_we <= 1'b0;
        end else begin
            if (FLUSH) begin
                r_s0_rd <= {AW{1'b0}};
                r_s0_we <= 1'b0;
                r_s0_ld <= 1'b0;
            end else if (!STALL) begin
                r_s0_rd <= IN_RD;
                r_s0_we <= w_we_in;
                r_s0_ld <= w_ld_in;
            end
            if (!STALL) begin
                r_s1_rd <= r_s0_rd;
                r_s1_we <= r_s0_we;
                r_s1_ld <= r_s0_ld;
                r_s2_rd <= r_s1_rd;
                r_s2_we <= r_s1_we;
            end
        end
    end

    // Forwarding selects, hazard and occupancy derive only from stage state.
    always_comb begin
        FWD_A_SEL = fwd_sel(SRC_A, r_s0_rd, r_s0_we, r_s1_rd, r_s1_we, r_s2_rd, r_s2_we);
        FWD_B_SEL = fwd_sel(SRC_B, r_s0_rd, r_s0_we, r_s1_rd, r_s1_we, r_s2_rd, r_s2_we);
        HAZ_LU    = r_s0_ld & ((FWD_A_SEL == 2'd1) | (FWD_B_SEL == 2'd1));
        BUSY      = r_s0_we | r_s1_we | r_s2_we;
    end

    assign OUT_WB_RD = r_s2_rd;
    assign OUT_WB_WE = r_s2_we;

    // The MEM-stage load flag is carried for completeness but never consulted:
    // a load in MEM is already forwardable.
    logic w_unused;
    assign w_unused = r_s1_ld;

endmodule
